// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch sequencer that feeds uart_tx through
// its trigger/busy handshake. Shares uart_tx's clock so frames go out
// back-to-back with only the handshake overhead between them.
module uart_tx_fifo #(
  parameter  int PAYLOAD_BITS = 8,
  parameter  int DEPTH        = 16,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_wr_en,
  input  logic [PAYLOAD_BITS-1:0] i_wr_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ADDR_W:0]         o_count,
  output logic                    o_overflow,
  output logic                    o_tx_trig,
  output logic [PAYLOAD_BITS-1:0] o_tx_data,
  input  logic                    i_tx_busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] TRIG      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       rd_ptr;
  logic [ADDR_W:0]         count;
  logic [ADDR_W:0]         count_nxt;
  logic [1:0]              state;
  logic                    wr_acc;
  logic                    pop;

  // Occupancy update; a write and a pop in the same cycle cancel out.
  // Writes are only accepted below DEPTH and pops only above zero, so the
  // result stays within 0..DEPTH.
  function automatic logic [ADDR_W:0] next_count(input logic [ADDR_W:0] cur,
                                                 input logic inc,
                                                 input logic dec);
    logic [ADDR_W:0] res;
    res = cur;
    if (inc && !dec)
      res = cur + (ADDR_W+1)'(1);
    else if (dec && !inc)
      res = cur - (ADDR_W+1)'(1);
    return res;
  endfunction

  // Flags are registered, so accept/pop decisions use last cycle's view of
  // the occupancy; a write arriving while full is dropped even if a pop
  // frees a slot on the same edge.
  assign wr_acc    = i_wr_en & ~o_full;
  assign pop       = (state == IDLE) & ~o_empty;
  assign count_nxt = next_count(count, wr_acc, pop);
  assign o_count   = count;

  // Storage array: data only, not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= i_wr_data;
  end

  // Pointers, occupancy, status flags and the sticky overflow bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      count   <= count_nxt;
      o_full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
      o_empty <= (count_nxt == '0);
      if (i_wr_en && o_full)
        o_overflow <= 1'b1;
    end
  end

  // Launch sequencer: pop a byte, pulse the trigger for one cycle, then
  // follow uart_tx busy high and back low before the next pop. o_tx_data
  // only changes on a pop, so it is steady for the whole frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      o_tx_trig <= 1'b0;
      o_tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_tx_trig <= 1'b0;
          if (!o_empty) begin
            o_tx_data <= mem[rd_ptr];
            state     <= TRIG;
          end
        end
        TRIG: begin
          o_tx_trig <= 1'b1;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // No timeout: a uart_tx that never asserts busy parks us here.
          o_tx_trig <= 1'b0;
          if (i_tx_busy)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          o_tx_trig <= 1'b0;
          if (!i_tx_busy)
            state <= IDLE;
        end
        default: begin
          o_tx_trig <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. A small behavioural uart_tx stand-in raises
// busy for FRAME cycles after each trigger. Stimulus pushes the bytes that
// should go on the line into a scoreboard queue; a negedge monitor pops and
// compares on every trigger pulse.
module tb_uart_tx_fifo;

  localparam int FRAME = 6;
  localparam int DEPTH = 16;

  logic       clk;
  logic       reset;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_tx_trig;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;

  logic       model_busy;
  logic       force_busy;
  int         frame_cnt;

  int         checks;
  int         errors;
  int         trig_cnt;
  logic       trig_prev;
  logic [7:0] last_sent;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.PAYLOAD_BITS(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_tx_trig  (o_tx_trig),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_tx_busy = model_busy | force_busy;

  // uart_tx stand-in: busy rises the edge after the trigger, lasts FRAME cycles.
  always @(posedge clk) begin
    if (reset) begin
      model_busy <= 1'b0;
      frame_cnt  <= 0;
    end else if (o_tx_trig) begin
      model_busy <= 1'b1;
      frame_cnt  <= FRAME;
    end else if (model_busy) begin
      if (frame_cnt == 1)
        model_busy <= 1'b0;
      frame_cnt <= frame_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: scoreboard on trigger pulses, plus per-cycle flag sanity.
  always @(negedge clk) begin
    if (!reset) begin
      chk("flag_consistency",
          {31'd0, (o_full !== (o_count == 5'd16)) || (o_empty !== (o_count == 5'd0)) ||
                  (o_count > 5'd16)}, 32'd0);
      if (o_tx_trig) begin
        if (trig_prev) begin
          chk("trig_width", 32'd2, 32'd1);
        end else begin
          trig_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_trig", {24'd0, o_tx_data}, 32'hffff_ffff);
          end else begin
            chk("tx_data", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
          end
          last_sent = o_tx_data;
        end
      end
      if (model_busy)
        chk("data_stable_in_frame", {24'd0, o_tx_data}, {24'd0, last_sent});
      trig_prev = o_tx_trig;
    end else begin
      trig_prev = 1'b0;
    end
  end

  // Called at a negedge; presents one byte for the next rising edge.
  task automatic wr(input logic [7:0] b, input bit expect_sent);
    i_wr_en   = 1'b1;
    i_wr_data = b;
    if (expect_sent)
      exp_q.push_back(b);
    @(negedge clk);
  endtask

  // Wait (bounded) until every expected byte has gone out and all is quiet.
  task automatic drain(input string name);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && o_empty && !i_tx_busy && !o_tx_trig)
        done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit idle_bad;
    checks     = 0;
    errors     = 0;
    trig_cnt   = 0;
    trig_prev  = 1'b0;
    last_sent  = 8'h00;
    force_busy = 1'b0;
    reset      = 1'b1;
    i_wr_en    = 1'b0;
    i_wr_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_empty",    {31'd0, o_empty},    32'd1);
    chk("rst_full",     {31'd0, o_full},     32'd0);
    chk("rst_count",    {27'd0, o_count},    32'd0);
    chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
    chk("rst_trig",     {31'd0, o_tx_trig},  32'd0);
    chk("rst_data",     {24'd0, o_tx_data},  32'd0);
    reset = 1'b0;

    // Idle for 100 cycles
    idle_bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (o_tx_trig || !o_empty || o_count != 5'd0)
        idle_bad = 1'b1;
    end
    chk("idle_quiet", {31'd0, idle_bad}, 32'd0);

    // Single byte: write edge, pop edge, trigger edge
    t0 = trig_cnt;
    wr(8'hab, 1'b1);
    i_wr_en = 1'b0;
    chk("single_after_write_empty", {31'd0, o_empty},   32'd0);
    chk("single_after_write_count", {27'd0, o_count},   32'd1);
    chk("single_after_write_trig",  {31'd0, o_tx_trig}, 32'd0);
    @(negedge clk);
    chk("single_after_pop_trig",  {31'd0, o_tx_trig}, 32'd0);
    chk("single_after_pop_empty", {31'd0, o_empty},   32'd1);
    chk("single_after_pop_data",  {24'd0, o_tx_data}, 32'h0000_00ab);
    @(negedge clk);
    chk("single_trig_edge3", {31'd0, o_tx_trig}, 32'd1);
    drain("single_drain");
    chk("single_trig_count", trig_cnt - t0, 32'd1);

    // Burst of three on consecutive cycles
    t0 = trig_cnt;
    wr(8'hab, 1'b1);
    wr(8'hcd, 1'b1);
    wr(8'hef, 1'b1);
    i_wr_en = 1'b0;
    chk("burst_count_peak", {27'd0, o_count}, 32'd2);
    drain("burst_drain");
    chk("burst_trig_count", trig_cnt - t0, 32'd3);

    // Fill with busy held: first byte in flight, 16 stored, 18th dropped
    t0 = trig_cnt;
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++)
      wr(8'(i), 1'b1);
    chk("fill_full",          {31'd0, o_full},     32'd1);
    chk("fill_count",         {27'd0, o_count},    32'd16);
    chk("fill_no_overflow",   {31'd0, o_overflow}, 32'd0);
    wr(8'h11, 1'b0);
    i_wr_en = 1'b0;
    chk("fill_overflow",      {31'd0, o_overflow}, 32'd1);
    chk("fill_count_after",   {27'd0, o_count},    32'd16);
    repeat (3) @(negedge clk);
    force_busy = 1'b0;
    drain("fill_drain");
    chk("fill_trig_count",    trig_cnt - t0, 32'd17);
    chk("overflow_sticky",    {31'd0, o_overflow}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("overflow_cleared",   {31'd0, o_overflow}, 32'd0);

    // Stream 40 bytes in bursts of 4 so writes land on pop edges and wrap
    t0 = trig_cnt;
    for (int i = 0; i < 40; i++) begin
      wr(8'(8'h40 + i), 1'b1);
      if (i % 4 == 3) begin
        i_wr_en = 1'b0;
        repeat (36) @(negedge clk);
      end
    end
    i_wr_en = 1'b0;
    drain("stream_drain");
    chk("stream_trig_count", trig_cnt - t0, 32'd40);
    chk("stream_no_overflow", {31'd0, o_overflow}, 32'd0);

    // Mid-frame reset with five bytes queued
    t0 = trig_cnt;
    wr(8'h90, 1'b1);
    for (int i = 1; i < 6; i++)
      wr(8'(8'h90 + i), 1'b0);
    i_wr_en = 1'b0;
    @(negedge clk);
    chk("midrst_queued", {27'd0, o_count}, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_count", {27'd0, o_count},   32'd0);
    chk("midrst_empty", {31'd0, o_empty},   32'd1);
    chk("midrst_trig",  {31'd0, o_tx_trig}, 32'd0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_nothing_sent", trig_cnt - t0, 32'd1);
    chk("midrst_sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
